// File: rtl/iprf_wr_arb.sv
// iprf_wr_arb
// Shares the single integer-PRF write port among NUM_REQ result producers.
// Each producer owns a DEPTH-entry FIFO; a round-robin scheduler drains at most
// one entry per cycle into a registered write packet that feeds the PRF write,
// ROB completion and result tracking. Flush discards everything still queued.
// A per-producer wait counter raises a sticky starvation flag at MAX_WAIT.
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   flush                discard all queued results, restart round-robin at 0
//   wr_block             write port reserved this cycle, no grant
//   req_valid/req_ready  per-producer push handshake
//   req_pdst/data/robid  per-producer payload, slice i = [i*W +: W]
//   wr_valid/pdst/data/robid/src  registered write packet (src one-hot)
//   busy                 any FIFO non-empty or packet valid
//   starve_err           sticky per-producer starvation flag
module iprf_wr_arb #(
   parameter int NUM_REQ  = 3,
   parameter int DEPTH    = 2,
   parameter int DATA_W   = 32,
   parameter int PDST_W   = 6,
   parameter int ROBID_W  = 5,
   parameter int MAX_WAIT = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       wr_block,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*PDST_W-1:0]  req_pdst,
   input  logic [NUM_REQ*DATA_W-1:0]  req_data,
   input  logic [NUM_REQ*ROBID_W-1:0] req_robid,
   output logic                       wr_valid,
   output logic [PDST_W-1:0]          wr_pdst,
   output logic [DATA_W-1:0]          wr_data,
   output logic [ROBID_W-1:0]         wr_robid,
   output logic [NUM_REQ-1:0]         wr_src,
   output logic                       busy,
   output logic [NUM_REQ-1:0]         starve_err
);

   localparam int CNT_W  = $clog2(DEPTH) + 1;
   localparam int SEL_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int IDX_W  = $clog2(NUM_REQ);
   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   localparam int ENT_W  = PDST_W + DATA_W + ROBID_W;

   logic [NUM_REQ-1:0]       nonempty;
   logic [NUM_REQ-1:0]       push;
   logic [NUM_REQ-1:0]       pop;
   logic [NUM_REQ-1:0]       wait_max;
   logic [NUM_REQ*ENT_W-1:0] head_flat;
   logic                     grant;
   logic [IDX_W-1:0]         rr_ptr;
   logic [IDX_W-1:0]         winner;
   logic [ENT_W-1:0]         win_ent;
   logic [2*NUM_REQ-1:0]     rot;
   int                       off_idx;
   int                       sum_idx;

   // Pointers wrap modulo DEPTH, which need not be a power of two.
   function automatic logic [CNT_W-1:0] ptr_inc(input logic [CNT_W-1:0] p);
      return (p == CNT_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // ---- per-producer FIFO and wait counter ----
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
      logic [ENT_W-1:0]  mem [DEPTH];
      logic [CNT_W-1:0]  count;
      logic [CNT_W-1:0]  rd_ptr;
      logic [CNT_W-1:0]  wr_ptr;
      logic [WAIT_W-1:0] wait_cnt;

      // Ready looks only at the current count: a full FIFO popped this cycle
      // still refuses the push.
      assign req_ready[g] = !reset && !flush && (count < CNT_W'(DEPTH));
      assign push[g]      = req_valid[g] && req_ready[g];
      assign nonempty[g]  = (count != '0);
      assign wait_max[g]  = (wait_cnt == WAIT_W'(MAX_WAIT));
      assign head_flat[g*ENT_W +: ENT_W] = mem[rd_ptr[SEL_W-1:0]];

      always_ff @(posedge clk) begin
         if (push[g])
            mem[wr_ptr[SEL_W-1:0]] <= {req_pdst[g*PDST_W +: PDST_W],
                                       req_data[g*DATA_W +: DATA_W],
                                       req_robid[g*ROBID_W +: ROBID_W]};
      end

      always_ff @(posedge clk) begin
         if (reset || flush) begin
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            wait_cnt <= '0;
         end else begin
            if (push[g])
               wr_ptr <= ptr_inc(wr_ptr);
            if (pop[g])
               rd_ptr <= ptr_inc(rd_ptr);
            if (push[g] && !pop[g])
               count <= count + 1'b1;
            else if (pop[g] && !push[g])
               count <= count - 1'b1;
            if (!nonempty[g] || pop[g])
               wait_cnt <= '0;
            else if (!wait_max[g])
               wait_cnt <= wait_cnt + 1'b1;
         end
      end
   end

   // ---- round-robin pick ----
   // Rotate the non-empty mask so rr_ptr lands at bit 0, then take the
   // lowest set bit; the winner is that offset added back to rr_ptr.
   always_comb begin
      rot     = {nonempty, nonempty} >> rr_ptr;
      grant   = 1'b0;
      off_idx = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            grant   = 1'b1;
            off_idx = k;
         end
      end
      sum_idx = int'(rr_ptr) + off_idx;
      if (sum_idx >= NUM_REQ)
         sum_idx = sum_idx - NUM_REQ;
      winner = IDX_W'(sum_idx);
      if (flush || wr_block)
         grant = 1'b0;
   end

   always_comb begin
      pop     = '0;
      win_ent = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant && (winner == IDX_W'(k))) begin
            pop[k]  = 1'b1;
            win_ent = head_flat[k*ENT_W +: ENT_W];
         end
      end
   end

   // ---- registered write packet ----
   // Without a grant only wr_valid drops; the payload fields keep their
   // last value.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_valid <= 1'b0;
         wr_pdst  <= '0;
         wr_data  <= '0;
         wr_robid <= '0;
         wr_src   <= '0;
         rr_ptr   <= '0;
      end else if (flush) begin
         wr_valid <= 1'b0;
         rr_ptr   <= '0;
      end else if (grant) begin
         wr_valid                     <= 1'b1;
         {wr_pdst, wr_data, wr_robid} <= win_ent;
         wr_src                       <= pop;
         rr_ptr <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
      end else begin
         wr_valid <= 1'b0;
      end
   end

   // Starvation flags survive flush; only reset clears them.
   always_ff @(posedge clk) begin
      if (reset)
         starve_err <= '0;
      else
         starve_err <= starve_err | wait_max;
   end

   assign busy = (|nonempty) | wr_valid;

   // A producer must not present a result while its FIFO refuses it.
   a_no_push_when_full : assert property (@(posedge clk) disable iff (reset || flush)
      ((req_valid & ~req_ready) == '0));

endmodule

// File: tb/tb_iprf_wr_arb.sv
// tb_iprf_wr_arb
// Bench for iprf_wr_arb: directed scenarios followed by random traffic, all
// compared every cycle against a queue-based reference model of the arbiter.
module tb_iprf_wr_arb;

   localparam int NUM_REQ  = 3;
   localparam int DEPTH    = 2;
   localparam int DATA_W   = 32;
   localparam int PDST_W   = 6;
   localparam int ROBID_W  = 5;
   localparam int MAX_WAIT = 16;

   typedef struct packed {
      logic [PDST_W-1:0]  pdst;
      logic [DATA_W-1:0]  data;
      logic [ROBID_W-1:0] robid;
   } pkt_t;

   logic                       clk = 1'b0;
   logic                       reset;
   logic                       flush;
   logic                       wr_block;
   logic [NUM_REQ-1:0]         req_valid;
   logic [NUM_REQ-1:0]         req_ready;
   logic [NUM_REQ*PDST_W-1:0]  req_pdst;
   logic [NUM_REQ*DATA_W-1:0]  req_data;
   logic [NUM_REQ*ROBID_W-1:0] req_robid;
   logic                       wr_valid;
   logic [PDST_W-1:0]          wr_pdst;
   logic [DATA_W-1:0]          wr_data;
   logic [ROBID_W-1:0]         wr_robid;
   logic [NUM_REQ-1:0]         wr_src;
   logic                       busy;
   logic [NUM_REQ-1:0]         starve_err;

   pkt_t in_pkt [NUM_REQ];
   int   checks = 0;
   int   errors = 0;

   // reference model state
   pkt_t               q [NUM_REQ][$];
   int                 rr;
   bit                 m_valid;
   pkt_t               m_pkt;
   logic [NUM_REQ-1:0] m_src;
   logic [NUM_REQ-1:0] m_starve;
   int                 m_wait [NUM_REQ];

   pkt_t p0;
   pkt_t p1;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
      assign req_pdst[g*PDST_W +: PDST_W]    = in_pkt[g].pdst;
      assign req_data[g*DATA_W +: DATA_W]    = in_pkt[g].data;
      assign req_robid[g*ROBID_W +: ROBID_W] = in_pkt[g].robid;
   end

   iprf_wr_arb #(
      .NUM_REQ(NUM_REQ), .DEPTH(DEPTH), .DATA_W(DATA_W),
      .PDST_W(PDST_W), .ROBID_W(ROBID_W), .MAX_WAIT(MAX_WAIT)
   ) dut (
      .clk(clk), .reset(reset), .flush(flush), .wr_block(wr_block),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_pdst(req_pdst), .req_data(req_data), .req_robid(req_robid),
      .wr_valid(wr_valid), .wr_pdst(wr_pdst), .wr_data(wr_data),
      .wr_robid(wr_robid), .wr_src(wr_src), .busy(busy), .starve_err(starve_err)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NUM_REQ-1:0] m_ready();
      logic [NUM_REQ-1:0] r;
      for (int i = 0; i < NUM_REQ; i++)
         r[i] = !reset && !flush && (q[i].size() < DEPTH);
      return r;
   endfunction

   function automatic bit m_busy();
      bit b;
      b = m_valid;
      for (int i = 0; i < NUM_REQ; i++)
         if (q[i].size() != 0) b = 1'b1;
      return b;
   endfunction

   task automatic rand_pkt(input int i);
      in_pkt[i].pdst  = PDST_W'($urandom);
      in_pkt[i].data  = $urandom;
      in_pkt[i].robid = ROBID_W'($urandom);
   endtask

   // Advance the model by one clock edge using the inputs of the ending cycle.
   task automatic model_step();
      bit empty_pre [NUM_REQ];
      bit popped    [NUM_REQ];
      logic [NUM_REQ-1:0] rdy;
      bit found;
      int w;
      int wi;
      if (reset) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            q[i].delete();
            m_wait[i] = 0;
         end
         rr = 0; m_valid = 0; m_pkt = '0; m_src = '0; m_starve = '0;
      end else begin
         rdy = '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            rdy[i]       = !flush && (q[i].size() < DEPTH);
            empty_pre[i] = (q[i].size() == 0);
            popped[i]    = 1'b0;
            if (m_wait[i] == MAX_WAIT) m_starve[i] = 1'b1;
         end
         if (flush) begin
            for (int i = 0; i < NUM_REQ; i++) begin
               q[i].delete();
               m_wait[i] = 0;
            end
            rr = 0;
            m_valid = 0;
         end else begin
            m_valid = 0;
            found = 0;
            wi = 0;
            if (!wr_block) begin
               for (int k = 0; k < NUM_REQ; k++) begin
                  w = (rr + k) % NUM_REQ;
                  if (!found && q[w].size() != 0) begin
                     found = 1;
                     wi = w;
                  end
               end
            end
            if (found) begin
               m_pkt      = q[wi].pop_front();
               m_src      = '0;
               m_src[wi]  = 1'b1;
               m_valid    = 1;
               popped[wi] = 1'b1;
               rr         = (wi + 1) % NUM_REQ;
            end
            for (int i = 0; i < NUM_REQ; i++)
               if (req_valid[i] && rdy[i]) q[i].push_back(in_pkt[i]);
            for (int i = 0; i < NUM_REQ; i++) begin
               if (empty_pre[i] || popped[i]) m_wait[i] = 0;
               else if (m_wait[i] < MAX_WAIT) m_wait[i] = m_wait[i] + 1;
            end
         end
      end
   endtask

   task automatic check_outputs();
      chk("req_ready", 64'(req_ready), 64'(m_ready()));
      chk("wr_valid", 64'(wr_valid), 64'(m_valid));
      chk("busy", 64'(busy), 64'(m_busy()));
      chk("starve_err", 64'(starve_err), 64'(m_starve));
      if (m_valid) begin
         chk("wr_pdst", 64'(wr_pdst), 64'(m_pkt.pdst));
         chk("wr_data", 64'(wr_data), 64'(m_pkt.data));
         chk("wr_robid", 64'(wr_robid), 64'(m_pkt.robid));
         chk("wr_src", 64'(wr_src), 64'(m_src));
      end
   endtask

   // One cycle: compare mid-cycle, take the edge, return just after it.
   task automatic tick();
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic drain();
      req_valid = '0;
      wr_block  = 1'b0;
      flush     = 1'b0;
      for (int n = 0; n < 4 * NUM_REQ * DEPTH && m_busy(); n++) tick();
      chk("drain_busy", 64'(busy), 64'd0);
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; wr_block = 1'b0; req_valid = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         in_pkt[i] = '0;
         m_wait[i] = 0;
      end
      rr = 0; m_valid = 0; m_pkt = '0; m_src = '0; m_starve = '0;
      @(posedge clk);
      model_step();
      #1;
      tick();
      tick();

      // reset state
      chk("rst_wr_valid", 64'(wr_valid), 64'd0);
      chk("rst_wr_pdst", 64'(wr_pdst), 64'd0);
      chk("rst_wr_data", 64'(wr_data), 64'd0);
      chk("rst_wr_robid", 64'(wr_robid), 64'd0);
      chk("rst_wr_src", 64'(wr_src), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_starve", 64'(starve_err), 64'd0);
      chk("rst_ready", 64'(req_ready), 64'd0);

      // single push, two-cycle latency
      reset = 1'b0;
      tick();
      in_pkt[1].pdst = 6'd5; in_pkt[1].data = 32'hDEAD_BEEF; in_pkt[1].robid = 5'd3;
      req_valid = 3'b010;
      tick();
      req_valid = '0;
      chk("t1_n1_valid", 64'(wr_valid), 64'd0);
      tick();
      chk("t1_valid", 64'(wr_valid), 64'd1);
      chk("t1_pdst", 64'(wr_pdst), 64'd5);
      chk("t1_data", 64'(wr_data), 64'hDEAD_BEEF);
      chk("t1_robid", 64'(wr_robid), 64'd3);
      chk("t1_src", 64'(wr_src), 64'b010);
      tick();
      chk("t1_after", 64'(wr_valid), 64'd0);

      // all producers push whenever ready
      for (int c = 0; c < 12; c++) begin
         for (int i = 0; i < NUM_REQ; i++) rand_pkt(i);
         req_valid = m_ready();
         tick();
         if (c >= 1) chk("t2_sustain", 64'(wr_valid), 64'd1);
      end
      drain();

      // fill FIFO 0 under wr_block, then release
      wr_block = 1'b1;
      rand_pkt(0); p0 = in_pkt[0]; req_valid = 3'b001;
      tick();
      rand_pkt(0); p1 = in_pkt[0];
      tick();
      req_valid = '0;
      for (int c = 0; c < 3; c++) begin
         chk("t3_ready0", 64'(req_ready[0]), 64'd0);
         chk("t3_blocked", 64'(wr_valid), 64'd0);
         tick();
      end
      wr_block = 1'b0;
      tick();
      chk("t3_w0_valid", 64'(wr_valid), 64'd1);
      chk("t3_w0_data", 64'(wr_data), 64'(p0.data));
      chk("t3_w0_pdst", 64'(wr_pdst), 64'(p0.pdst));
      tick();
      chk("t3_w1_valid", 64'(wr_valid), 64'd1);
      chk("t3_w1_data", 64'(wr_data), 64'(p1.data));
      tick();
      chk("t3_done", 64'(wr_valid), 64'd0);
      drain();

      // flush while a packet is valid
      rand_pkt(0); rand_pkt(2); req_valid = 3'b101;
      tick();
      rand_pkt(0); rand_pkt(2);
      tick();
      req_valid = '0;
      chk("t4_pre_valid", 64'(wr_valid), 64'd1);
      flush = 1'b1;
      #1;
      chk("t4_flush_ready", 64'(req_ready), 64'd0);
      chk("t4_flush_pkt", 64'(wr_valid), 64'd1);
      tick();
      flush = 1'b0;
      chk("t4_post_valid", 64'(wr_valid), 64'd0);
      chk("t4_post_busy", 64'(busy), 64'd0);
      for (int i = 0; i < NUM_REQ; i++) rand_pkt(i);
      req_valid = 3'b111;
      tick();
      req_valid = '0;
      tick();
      chk("t4_rr0_valid", 64'(wr_valid), 64'd1);
      chk("t4_rr0_src", 64'(wr_src), 64'b001);
      drain();

      // starvation on producer 2
      wr_block = 1'b1;
      rand_pkt(2); req_valid = 3'b100;
      tick();
      req_valid = '0;
      for (int c = 0; c < 10; c++) tick();
      chk("t5_early", 64'(starve_err), 64'd0);
      for (int c = 0; c < 10; c++) tick();
      chk("t5_set", 64'(starve_err), 64'b100);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      chk("t5_kept", 64'(starve_err), 64'b100);

      // reset (with flush) while FIFOs are full
      for (int c = 0; c < 2; c++) begin
         for (int i = 0; i < NUM_REQ; i++) rand_pkt(i);
         req_valid = 3'b111;
         tick();
      end
      req_valid = '0;
      chk("t6_full_ready", 64'(req_ready), 64'd0);
      chk("t6_full_busy", 64'(busy), 64'd1);
      reset = 1'b1; flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t6_rst_valid", 64'(wr_valid), 64'd0);
      chk("t6_rst_busy", 64'(busy), 64'd0);
      chk("t6_rst_starve", 64'(starve_err), 64'd0);
      chk("t6_rst_ready", 64'(req_ready), 64'd0);
      chk("t6_rst_pdst", 64'(wr_pdst), 64'd0);
      chk("t6_rst_src", 64'(wr_src), 64'd0);
      tick();
      reset = 1'b0; wr_block = 1'b0;
      #1;
      chk("t6_ready_after", 64'(req_ready), 64'b111);

      // random traffic: light then heavy write-port blocking
      for (int phase = 0; phase < 2; phase++) begin
         for (int c = 0; c < 300; c++) begin
            reset    = ($urandom_range(0, 199) == 0);
            flush    = ($urandom_range(0, 99) < 4);
            wr_block = ($urandom_range(0, 99) < ((phase == 0) ? 25 : 85));
            for (int i = 0; i < NUM_REQ; i++) begin
               rand_pkt(i);
               req_valid[i] = ($urandom_range(0, 99) < 60) &&
                              (reset || flush || (q[i].size() < DEPTH));
            end
            tick();
         end
      end
      reset = 1'b0;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
